// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module : conv_pkg
// Brief  : Shared types and constants for the convolution layer and its feeder.
// Rev    : 1.0
// ============================================================================
package conv_pkg;

    localparam int WORD_W         = 32;
    localparam int DEF_IMG_DIM    = 32;
    localparam int DEF_KERNEL_DIM = 5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } feeder_state_e;

    // Bits needed to hold values 0..value-1, never less than 1.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_layer_feeder_if.sv
`default_nettype none
// ============================================================================
// Module : conv_layer_feeder_if
// Brief  : Valid/ready word stream from the DMA FIFO into the layer feeder.
// Rev    : 1.0
// ============================================================================
interface conv_layer_feeder_if;
    import conv_pkg::*;

    logic [WORD_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (output s_data, output s_valid, input  s_ready);
    modport slave  (input  s_data, input  s_valid, output s_ready);

endinterface
`default_nettype wire

// File: rtl/feeder_beat_counter.sv
`default_nettype none
// ============================================================================
// Module : feeder_beat_counter
// Brief  : Terminal-count counter with clear and enable; returns to 0 after term.
// Rev    : 1.0
// ============================================================================
module feeder_beat_counter #(
    parameter int WIDTH = 4
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             clr,
    input  wire logic             en,
    input  wire logic [WIDTH-1:0] term,
    output logic      [WIDTH-1:0] count,
    output logic                  last
);

    logic [WIDTH-1:0] r_count;

    assign count = r_count;
    assign last  = (r_count == term);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= last ? '0 : r_count + WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv_layer_feeder.sv
`default_nettype none
// ============================================================================
// Module : conv_layer_feeder
// Brief  : Routes weight then pixel beats per input set to the conv layer.
//          Optional stall counter output under FEEDER_STALL_COUNT_EN.
// Rev    : 1.0
// ============================================================================
module conv_layer_feeder
    import conv_pkg::*;
#(
    parameter int IMG_DIM      = DEF_IMG_DIM,
    parameter int KERNEL_DIM   = DEF_KERNEL_DIM,
    parameter int WEIGHT_WORDS = KERNEL_DIM * KERNEL_DIM + 3,
    parameter int DRAIN_CYCLES = 16
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              start,
    input  wire logic [WORD_W-1:0] cfg_layer_nr,
    input  wire logic [15:0]       cfg_num_sets,
    conv_layer_feeder_if.slave     s,
    output logic      [WORD_W-1:0] layer_nr,
    output logic                   weight_we,
    output logic      [WORD_W-1:0] weight_data,
    output logic                   conv_en,
    output logic      [WORD_W-1:0] pixel_in,
    output logic                   final_set,
    output logic                   busy,
    output logic                   done
`ifdef FEEDER_STALL_COUNT_EN
    ,
    output logic      [31:0]       stall_cycles
`endif
);

    localparam int PIX_BEATS = IMG_DIM * IMG_DIM;
    localparam int MAX_BEATS = (WEIGHT_WORDS > PIX_BEATS) ? WEIGHT_WORDS : PIX_BEATS;
    localparam int BEAT_W    = clog2(MAX_BEATS);
    localparam int DRAIN_W   = clog2(DRAIN_CYCLES + 1);

    localparam logic [BEAT_W-1:0]  C_W_LAST = BEAT_W'(WEIGHT_WORDS - 1);
    localparam logic [BEAT_W-1:0]  C_P_LAST = BEAT_W'(PIX_BEATS - 1);
    localparam logic [DRAIN_W-1:0] C_D_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

    localparam logic [2:0] ST_IDLE   = IDLE;
    localparam logic [2:0] ST_LOAD_W = LOAD_W;
    localparam logic [2:0] ST_STREAM = STREAM;
    localparam logic [2:0] ST_DRAIN  = DRAIN;
    localparam logic [2:0] ST_DONE   = DONE;

    logic [2:0]        r_state;
    logic [15:0]       r_set_cnt;
    logic [15:0]       r_num_sets;
    logic [WORD_W-1:0] r_layer;
    logic              r_final;
    logic              w_fire;
    logic              w_start_ok;
    logic              w_beat_last;
    logic              w_drain_last;
    logic              w_drain_clr;
    logic [BEAT_W-1:0] w_beat_cnt;
    logic [DRAIN_W-1:0] w_drain_cnt;

    assign s.s_ready    = (r_state == ST_LOAD_W) || (r_state == ST_STREAM);
    assign w_fire       = s.s_valid && s.s_ready;
    assign w_start_ok   = start && (r_state == ST_IDLE);
    assign w_drain_clr  = w_fire && w_beat_last && (r_state == ST_STREAM);

    assign busy      = (r_state != ST_IDLE);
    assign layer_nr  = r_layer;
    assign final_set = r_final;

    // Terminal value switches with the phase, so one counter serves both.
    feeder_beat_counter #(.WIDTH(BEAT_W)) u_beat_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (w_start_ok),
        .en    (w_fire),
        .term  ((r_state == ST_STREAM) ? C_P_LAST : C_W_LAST),
        .count (w_beat_cnt),
        .last  (w_beat_last)
    );

    feeder_beat_counter #(.WIDTH(DRAIN_W)) u_drain_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (w_drain_clr),
        .en    (r_state == ST_DRAIN),
        .term  (C_D_LAST),
        .count (w_drain_cnt),
        .last  (w_drain_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_set_cnt  <= '0;
            r_num_sets <= '0;
            r_layer    <= '0;
            r_final    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_layer    <= cfg_layer_nr;
                        r_num_sets <= (cfg_num_sets == 16'd0) ? 16'd1 : cfg_num_sets;
                        r_set_cnt  <= '0;
                        r_final    <= (cfg_num_sets <= 16'd1);
                        r_state    <= ST_LOAD_W;
                    end
                end
                ST_LOAD_W: begin
                    if (w_fire && w_beat_last) r_state <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (w_fire && w_beat_last) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (w_drain_last) begin
                        if (r_set_cnt == r_num_sets - 16'd1) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_set_cnt <= r_set_cnt + 16'd1;
                            r_final   <= (r_set_cnt + 16'd2 == r_num_sets);
                            r_state   <= ST_LOAD_W;
                        end
                    end
                end
                ST_DONE: begin
                    r_final <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            weight_we   <= 1'b0;
            weight_data <= '0;
            conv_en     <= 1'b0;
            pixel_in    <= '0;
            done        <= 1'b0;
        end else begin
            weight_we <= w_fire && (r_state == ST_LOAD_W);
            conv_en   <= w_fire && (r_state == ST_STREAM);
            done      <= (r_state == ST_DONE);
            if (w_fire && (r_state == ST_LOAD_W)) weight_data <= s.s_data;
            if (w_fire && (r_state == ST_STREAM)) pixel_in    <= s.s_data;
        end
    end

`ifdef FEEDER_STALL_COUNT_EN
    logic [31:0] r_stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall <= '0;
        end else if (w_start_ok) begin
            r_stall <= '0;
        end else if (s.s_ready && !s.s_valid && (r_stall != 32'hFFFF_FFFF)) begin
            r_stall <= r_stall + 32'd1;
        end
    end

    assign stall_cycles = r_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv_layer_feeder.sv
`default_nettype none
// ============================================================================
// Module : tb_conv_layer_feeder
// Brief  : Randomized self-checking bench for conv_layer_feeder against a beat-level model.
// Rev    : 1.0
// ============================================================================
module tb_conv_layer_feeder;

    localparam int WW  = 28;
    localparam int PIX = 1024;
    localparam int BPS = WW + PIX;
    localparam int DRN = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] cfg_layer_nr = '0;
    logic [15:0] cfg_num_sets = '0;
    logic [31:0] layer_nr, weight_data, pixel_in;
    logic        weight_we, conv_en, final_set, busy, done;
`ifdef FEEDER_STALL_COUNT_EN
    logic [31:0] stall_cycles;
`endif

    conv_layer_feeder_if sif();

    conv_layer_feeder dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cfg_layer_nr (cfg_layer_nr),
        .cfg_num_sets (cfg_num_sets),
        .s            (sif.slave),
        .layer_nr     (layer_nr),
        .weight_we    (weight_we),
        .weight_data  (weight_data),
        .conv_en      (conv_en),
        .pixel_in     (pixel_in),
        .final_set    (final_set),
        .busy         (busy),
        .done         (done)
`ifdef FEEDER_STALL_COUNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: job phase 0 idle, 1 accepting beats, 2 draining, 3 closing, 4 done pulse.
    int          ph, set_i, beat_i, drain_left, nsets;
    logic [31:0] m_layer, e_wdata, e_pdata, m_stall;
    logic        e_we, e_en;

    int          n_we, n_en, n_en_fin, n_done, gap_n, gap_min, gap_max, low_run;
    int          cyc, first_en_cyc, last_en_cyc, done_cyc;
    logic [31:0] first_w;
    bit          first_w_set, first_en_set;
    logic [31:0] job_seed;

    task automatic clear_stats();
        n_we = 0; n_en = 0; n_en_fin = 0; n_done = 0;
        gap_n = 0; gap_min = 1 << 30; gap_max = 0;
        first_w_set = 1'b0; first_en_set = 1'b0; first_w = '0;
        first_en_cyc = 0; last_en_cyc = 0; done_cyc = 0;
    endtask

    always @(negedge clk) begin
        bit fire;
        cyc++;
        if (!reset) begin
            ph = 0; set_i = 0; beat_i = 0; drain_left = 0; nsets = 1;
            m_layer = '0; e_wdata = '0; e_pdata = '0; m_stall = '0;
            e_we = 1'b0; e_en = 1'b0; low_run = 0;
            chk("rst_weight_we", 32'(weight_we), 32'd0);
            chk("rst_conv_en", 32'(conv_en), 32'd0);
            chk("rst_weight_data", weight_data, 32'd0);
            chk("rst_pixel_in", pixel_in, 32'd0);
            chk("rst_final_set", 32'(final_set), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_s_ready", 32'(sif.s_ready), 32'd0);
            chk("rst_layer_nr", layer_nr, 32'd0);
`ifdef FEEDER_STALL_COUNT_EN
            chk("rst_stall_cycles", stall_cycles, 32'd0);
`endif
        end else begin
            chk("weight_we", 32'(weight_we), 32'(e_we));
            chk("weight_data", weight_data, e_wdata);
            chk("conv_en", 32'(conv_en), 32'(e_en));
            chk("pixel_in", pixel_in, e_pdata);
            chk("s_ready", 32'(sif.s_ready), 32'(ph == 1));
            chk("busy", 32'(busy), 32'(ph >= 1 && ph <= 3));
            chk("done", 32'(done), 32'(ph == 4));
            chk("final_set", 32'(final_set), 32'((ph >= 1 && ph <= 3) && (set_i == nsets - 1)));
            chk("layer_nr", layer_nr, m_layer);
`ifdef FEEDER_STALL_COUNT_EN
            chk("stall_cycles", stall_cycles, m_stall);
`endif
            if (weight_we) begin
                n_we++;
                if (!first_w_set) begin first_w = weight_data; first_w_set = 1'b1; end
            end
            if (conv_en) begin
                n_en++;
                if (!first_en_set) begin first_en_cyc = cyc; first_en_set = 1'b1; end
                last_en_cyc = cyc;
                if (final_set) n_en_fin++;
            end
            if (done) begin n_done++; done_cyc = cyc; end
            if (!busy) low_run = 0;
            else if (!sif.s_ready) low_run++;
            else if (low_run > 0) begin
                gap_n++;
                if (low_run < gap_min) gap_min = low_run;
                if (low_run > gap_max) gap_max = low_run;
                low_run = 0;
            end

            fire = (ph == 1) && sif.s_valid;
            e_we = fire && (beat_i < WW);
            e_en = fire && (beat_i >= WW);
            if (e_we) e_wdata = sif.s_data;
            if (e_en) e_pdata = sif.s_data;
            if (ph == 1 && !sif.s_valid && m_stall != 32'hFFFF_FFFF) m_stall++;
            case (ph)
                0, 4: begin
                    ph = 0;
                    if (start) begin
                        m_layer = cfg_layer_nr;
                        nsets   = (cfg_num_sets == 16'd0) ? 1 : int'(cfg_num_sets);
                        set_i = 0; beat_i = 0; m_stall = '0; ph = 1;
                    end
                end
                1: if (fire) begin
                    beat_i++;
                    if (beat_i == BPS) begin beat_i = 0; drain_left = DRN; ph = 2; end
                end
                2: begin
                    drain_left--;
                    if (drain_left == 0) begin
                        if (set_i == nsets - 1) ph = 3;
                        else begin set_i++; ph = 1; end
                    end
                end
                default: ph = 4;
            endcase
        end
    end

    function automatic logic [31:0] word(input int idx, input bit pattern, input logic [31:0] seed);
        int b;
        b = idx % BPS;
        if (pattern) return (b < WW) ? 32'((b + 1) << 16) : 32'(b - WW);
        return (32'(idx) * 32'h9E37_79B9) ^ seed;
    endfunction

    task automatic run_job(input logic [31:0] layer, input logic [15:0] ns, input int pct,
                           input bit pattern, input int abort_at, input bit mid_start,
                           input bit late_start);
        int eff, total, idx, budget, cyc_l;
        bit fire, pulsed;
        eff = (ns == 16'd0) ? 1 : int'(ns);
        total = eff * BPS; idx = 0; budget = total * 8 + 200; cyc_l = 0; pulsed = 1'b0;
        job_seed = $urandom;
        clear_stats();
        cfg_layer_nr = layer; cfg_num_sets = ns; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (idx < total && cyc_l < budget) begin
            sif.s_valid = (pct >= 100) ? 1'b1 : (int'($urandom_range(0, 99)) < pct);
            sif.s_data  = word(idx, pattern, job_seed);
            if (mid_start && !pulsed && idx >= WW + 300) begin
                start = 1'b1; cfg_layer_nr = 32'hDEAD_BEEF; cfg_num_sets = 16'd7; pulsed = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            fire = sif.s_valid && sif.s_ready;
            @(posedge clk); #1;
            cyc_l++;
            if (fire) idx++;
            if (abort_at >= 0 && idx == abort_at) begin
                #1 reset = 1'b0;
                #1;
                chk("async_conv_en", 32'(conv_en), 32'd0);
                chk("async_busy", 32'(busy), 32'd0);
                chk("async_s_ready", 32'(sif.s_ready), 32'd0);
                chk("async_final_set", 32'(final_set), 32'd0);
                chk("async_layer_nr", layer_nr, 32'd0);
                sif.s_valid = 1'b0; start = 1'b0;
                repeat (3) @(posedge clk);
                #1 reset = 1'b1;
                repeat (30) @(posedge clk);
                #1;
                chk("abort_no_done", 32'(n_done), 32'd0);
                chk("abort_idle", 32'(busy), 32'd0);
                return;
            end
        end
        start = 1'b0; sif.s_valid = 1'b0;
        chk("job_beats", 32'(idx), 32'(total));
        for (int w = 0; w < 300 && n_done == 0; w++) begin
            @(posedge clk); #1;
            start = late_start && (ph == 3);
        end
        start = 1'b0;
        chk("done_seen", 32'(n_done), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("done_once", 32'(n_done), 32'd1);
        chk("idle_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        sif.s_valid = 1'b0;
        sif.s_data  = '0;
        cyc = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single set, patterned words, s_valid always high.
        run_job(32'd0, 16'd1, 100, 1'b1, -1, 1'b0, 1'b0);
        chk("t1_we_count", 32'(n_we), 32'd28);
        chk("t1_en_count", 32'(n_en), 32'd1024);
        chk("t1_first_w", first_w, 32'h0001_0000);
        chk("t1_last_w", weight_data, 32'h001C_0000);
        chk("t1_last_pix", pixel_in, 32'd1023);
        chk("t1_en_contig", 32'(last_en_cyc - first_en_cyc), 32'd1023);
        chk("t1_en_final", 32'(n_en_fin), 32'd1024);
        chk("t1_done_lat", 32'(done_cyc - last_en_cyc), 32'd17);

        // Three sets; start pulsed during the closing cycle must be ignored.
        run_job(32'd1, 16'd3, 100, 1'b1, -1, 1'b0, 1'b1);
        chk("t2_we_count", 32'(n_we), 32'd84);
        chk("t2_en_count", 32'(n_en), 32'd3072);
        chk("t2_en_final", 32'(n_en_fin), 32'd1024);
        chk("t2_gap_n", 32'(gap_n), 32'd2);
        chk("t2_gap_min", 32'(gap_min), 32'd16);
        chk("t2_gap_max", 32'(gap_max), 32'd16);
        chk("t2_layer", layer_nr, 32'd1);

        // Random data, 50% valid.
        run_job(32'h0000_0007, 16'd2, 50, 1'b0, -1, 1'b0, 1'b0);
        chk("t3_we_count", 32'(n_we), 32'd56);
        chk("t3_en_count", 32'(n_en), 32'd2048);
        chk("t3_gap_n", 32'(gap_n), 32'd1);
        chk("t3_gap_min", 32'(gap_min), 32'd16);

        // Reset at pixel 500, then a fresh job.
        run_job(32'd2, 16'd1, 100, 1'b1, WW + 500, 1'b0, 1'b0);
        run_job(32'd3, 16'd1, 70, 1'b0, -1, 1'b0, 1'b0);
        chk("t4_en_count", 32'(n_en), 32'd1024);
        chk("t4_layer", layer_nr, 32'd3);

        // num_sets=0 acts as 1; a second start mid-stream is ignored.
        run_job(32'd5, 16'd0, 100, 1'b0, -1, 1'b1, 1'b0);
        chk("t5_layer", layer_nr, 32'd5);
        chk("t5_we_count", 32'(n_we), 32'd28);
        chk("t5_en_count", 32'(n_en), 32'd1024);
        chk("t5_en_final", 32'(n_en_fin), 32'd1024);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
